dac_soft_mute: RTL and testbench
================================

Name: dac_soft_mute

Overview:
- Downstream stage of the receive core; one instance sits on each DAC output bus (dac1/dac2/dac3) between the core and the RF-DAC.
- Applies a linear soft-mute/unmute gain ramp to 8 parallel 16-bit samples per clock, so DAC enable/disable produces no output steps.
- Gain is unsigned Q1.15; unity is 0x8000. The datapath is a 2-stage pipeline.

Parameters:
- SAMPLES_PER_CLK, 8, parallel samples per bus word.
- SAMPLE_WIDTH, 16, signed two's-complement sample width.
- GAIN_WIDTH, 16, ramp gain register width, unsigned Q1.15.

Ports:
- clock  in  1  DAC-domain clock, same clock as the core's dac*_data.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = ramp to unity, 0 = ramp to mute; level-sensitive.
- ramp_step  in  GAIN_WIDTH  gain increment/decrement per valid word; quasi-static.
- data_in  in  SAMPLES_PER_CLK*SAMPLE_WIDTH  sample k at bits [16k+15:16k].
- data_in_valid  in  1  qualifies data_in; gain/FSM advance only on valid cycles.
- data_out  out  SAMPLES_PER_CLK*SAMPLE_WIDTH  gain-scaled samples.
- data_out_valid  out  1  data_in_valid delayed 2 cycles.
- muted  out  1  registered, 1 while state = MUTED.
- active  out  1  registered, 1 while state = ACTIVE.
- ramp_done  out  1  one-cycle pulse when a ramp completes (either direction).

Behaviour:
- Reset (async assert, sync deassert by the upstream reset bridge):
  - state = MUTED, gain = 0.
  - data_out = 0, data_out_valid = 0, muted = 1, active = 0, ramp_done = 0.
  - Pipeline contents are discarded.
- Effective step: step_eff = ramp_step; a step of 0 is treated as 1, so every ramp terminates.
- FSM, evaluated only on cycles with data_in_valid = 1. On invalid cycles, state and gain hold.
  - MUTED: if enable, go to RAMP_UP; gain is unchanged that cycle (stays 0).
  - RAMP_UP:
    - if !enable, go to RAMP_DOWN; gain is unchanged that cycle.
    - else if gain + step_eff >= 0x8000: gain = 0x8000, go to ACTIVE, ramp_done pulses the next cycle.
    - else gain += step_eff.
  - ACTIVE: if !enable, go to RAMP_DOWN; gain holds at 0x8000.
  - RAMP_DOWN:
    - if enable, go to RAMP_UP; gain is unchanged.
    - else if gain <= step_eff: gain = 0, go to MUTED, ramp_done pulses.
    - else gain -= step_eff.
  - Reversal mid-ramp continues from the current gain; there is no jump.
- Datapath, per lane:
  - Stage 1 registers the product p = sample * gain. The gain used is the register value before that cycle's update. p is a signed 33-bit value (gain zero-extended).
  - Stage 2 computes y = (p + 0x4000) >>> 15 (round half up, arithmetic shift).
  - Since gain <= 0x8000, y always fits in SAMPLE_WIDTH and no saturation is required. Gain 0x8000 gives y = x exactly.
- Latency: data_out and data_out_valid are registered, 2 clocks after data_in.
  - data_out is forced to 0 on cycles where data_out_valid = 0.
- muted, active and ramp_done are registered from the FSM next-state. They update on the same edge as the state register.
- The ramp length in valid words is ceil(0x8000 / step_eff).
- The stream may stall (data_in_valid = 0) indefinitely mid-ramp; the gain freezes.

Optional Feature:
- Macro: DAC_SOFT_MUTE_OFFSET_BINARY_EN.
- Defined: each data_out sample has its MSB inverted (offset-binary for DAC). Forced-zero output when invalid becomes 0x8000 per lane; the reset value is also 0x8000 per lane.
- Undefined: two's-complement output as specified above.

Decomposition:
- Package dac_soft_mute_pkg:
  - state enum {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN}.
  - GAIN_UNITY = 16'h8000.
  - ROUND_CONST = 33'h4000.
  - Q_SHIFT = 15.
- Sub-module dac_gain_lane: one sample, 2-stage multiply/round.
  - Instantiated SAMPLES_PER_CLK times by generate.
  - The FSM/gain register stays in the top level.

Test Plan:
- Reset/idle: hold reset_n = 0, then release with enable = 0 and a constant valid input of 0x7FFF on all lanes.
  - Expect data_out = 0, muted = 1, active = 0, ramp_done never asserts.
- Unmute, step 0x4000: raise enable with a continuous valid input of 0x4000.
  - Gains per word are 0, 0, 0x4000, 0x8000, so data_out = 0, 0, 0x2000, 0x4000, 2 clocks later.
  - ramp_done pulses once; then active = 1.
- Rounding at gain 0x4000: inputs -1, -3, 0x7FFF.
  - Outputs 0, -1 (0xFFFF), 0x4000.
- Mid-ramp reversal: step 0x0100, enable = 1 for 10 valid words, then enable = 0.
  - Gain peaks at 0x0900, holds 1 word, then decrements.
  - MUTED is reached after 9 more words; a single ramp_done pulse.
- Stall and step zero: ramp_step = 0 with data_in_valid toggling 1/0.
  - Gain advances by 1 per valid word only.
  - data_out_valid mirrors data_in_valid delayed 2 clocks.
  - data_out = 0 on invalid cycles.
- Async reset mid-ramp at gain 0x3000.
  - Outputs return to their reset values immediately, without waiting for a clock edge.
  - After release, the block restarts in MUTED with gain 0.

Source files
------------

// File: rtl/dac_soft_mute_pkg.sv
// dac_soft_mute_pkg: shared types and constants for the DAC soft-mute block.
package dac_soft_mute_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Unity gain in unsigned Q1.15.
  localparam logic [15:0] GAIN_UNITY  = 16'h8000;
  // Half an LSB of the Q1.15 product, for round-half-up.
  localparam logic [32:0] ROUND_CONST = 33'h4000;
  localparam int          Q_SHIFT     = 15;

endpackage : dac_soft_mute_pkg

// File: rtl/dac_soft_mute_if.sv
// dac_soft_mute_if: control and sample bus of one soft-mute instance.
// master = upstream core / driver side, slave = dac_soft_mute.
interface dac_soft_mute_if #(
  parameter int SAMPLES_PER_CLK = 8,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int GAIN_WIDTH      = 16
);

  logic                                    enable;
  logic [GAIN_WIDTH-1:0]                   ramp_step;
  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] data_in;
  logic                                    data_in_valid;
  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] data_out;
  logic                                    data_out_valid;
  logic                                    muted;
  logic                                    active;
  logic                                    ramp_done;

  modport master (
    output enable, ramp_step, data_in, data_in_valid,
    input  data_out, data_out_valid, muted, active, ramp_done
  );

  modport slave (
    input  enable, ramp_step, data_in, data_in_valid,
    output data_out, data_out_valid, muted, active, ramp_done
  );

endinterface : dac_soft_mute_if

// File: rtl/dac_gain_lane.sv
// dac_gain_lane: one sample lane, stage 1 = sample * gain, stage 2 = round,
// shift back to Q0 and force the idle value when the word is not valid.
// Optional: DAC_SOFT_MUTE_OFFSET_BINARY_EN inverts the output MSB (offset binary).
module dac_gain_lane
  import dac_soft_mute_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic [GAIN_WIDTH-1:0]   i_gain,
  input  logic                    i_valid_s1,
  output logic [SAMPLE_WIDTH-1:0] o_sample
);

  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] ROUND = PW'(ROUND_CONST);

`ifdef DAC_SOFT_MUTE_OFFSET_BINARY_EN
  localparam logic [SAMPLE_WIDTH-1:0] OUT_IDLE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
`else
  localparam logic [SAMPLE_WIDTH-1:0] OUT_IDLE = '0;
`endif

  logic signed [PW-1:0]    w_x_ext;
  logic signed [PW-1:0]    w_g_ext;
  logic signed [PW-1:0]    w_sum;
  logic signed [PW-1:0]    r_prod;
  logic [SAMPLE_WIDTH-1:0] w_y;
  logic [SAMPLE_WIDTH-1:0] w_out;
  logic [SAMPLE_WIDTH-1:0] r_out;

  // Sample sign-extended, gain zero-extended, so the product is a plain signed multiply.
  assign w_x_ext = {{(PW-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
  assign w_g_ext = {{(PW-GAIN_WIDTH){1'b0}}, i_gain};
  assign w_sum   = r_prod + ROUND;
  // Gain never exceeds unity, so the shifted result always fits the sample width.
  assign w_y     = SAMPLE_WIDTH'(w_sum >>> Q_SHIFT);

`ifdef DAC_SOFT_MUTE_OFFSET_BINARY_EN
  assign w_out = {~w_y[SAMPLE_WIDTH-1], w_y[SAMPLE_WIDTH-2:0]};
`else
  assign w_out = w_y;
`endif

  // Stage 1: register the full-precision product.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_x_ext * w_g_ext;
    end
  end

  // Stage 2: rounded output, idle value when the word is not valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= OUT_IDLE;
    end else begin
      r_out <= i_valid_s1 ? w_out : OUT_IDLE;
    end
  end

  assign o_sample = r_out;

endmodule : dac_gain_lane

// File: rtl/dac_soft_mute.sv
// dac_soft_mute: linear soft mute/unmute gain ramp on a parallel DAC sample bus.
// Gain FSM lives here; per-sample multiply/round is in dac_gain_lane.
// Optional: DAC_SOFT_MUTE_OFFSET_BINARY_EN selects offset-binary output samples.
module dac_soft_mute
  import dac_soft_mute_pkg::*;
#(
  parameter int SAMPLES_PER_CLK = 8,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int GAIN_WIDTH      = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  dac_soft_mute_if.slave  bus
);

  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(GAIN_UNITY);

  state_t                                  r_state;
  state_t                                  w_state_nxt;
  logic [GAIN_WIDTH-1:0]                   r_gain;
  logic [GAIN_WIDTH-1:0]                   w_gain_nxt;
  logic [GAIN_WIDTH-1:0]                   w_step_eff;
  logic [GAIN_WIDTH:0]                     w_gain_sum;
  logic                                    w_done_nxt;
  logic                                    r_muted;
  logic                                    r_active;
  logic                                    r_ramp_done;
  logic                                    r_valid_s1;
  logic                                    r_valid_s2;
  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] w_data_out;

  // A zero step would never finish a ramp, so it is treated as one LSB.
  assign w_step_eff = (bus.ramp_step == '0) ? GAIN_WIDTH'(1) : bus.ramp_step;
  assign w_gain_sum = {1'b0, r_gain} + {1'b0, w_step_eff};

  // Next state / gain; only valid words advance the ramp.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_done_nxt  = 1'b0;
    if (bus.data_in_valid) begin
      case (r_state)
        MUTED: begin
          if (bus.enable) w_state_nxt = RAMP_UP;
        end
        RAMP_UP: begin
          if (!bus.enable) begin
            w_state_nxt = RAMP_DOWN;
          end else if (w_gain_sum >= {1'b0, UNITY}) begin
            w_gain_nxt  = UNITY;
            w_state_nxt = ACTIVE;
            w_done_nxt  = 1'b1;
          end else begin
            w_gain_nxt = w_gain_sum[GAIN_WIDTH-1:0];
          end
        end
        ACTIVE: begin
          if (!bus.enable) w_state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (bus.enable) begin
            w_state_nxt = RAMP_UP;
          end else if (r_gain <= w_step_eff) begin
            w_gain_nxt  = '0;
            w_state_nxt = MUTED;
            w_done_nxt  = 1'b1;
          end else begin
            w_gain_nxt = r_gain - w_step_eff;
          end
        end
        default: begin
          w_state_nxt = MUTED;
          w_gain_nxt  = '0;
        end
      endcase
    end
  end

  // State, gain and status flags, all registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= MUTED;
      r_gain      <= '0;
      r_muted     <= 1'b1;
      r_active    <= 1'b0;
      r_ramp_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gain      <= w_gain_nxt;
      r_muted     <= (w_state_nxt == MUTED);
      r_active    <= (w_state_nxt == ACTIVE);
      r_ramp_done <= w_done_nxt;
    end
  end

  // Valid pipeline matching the two datapath stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
    end else begin
      r_valid_s1 <= bus.data_in_valid;
      r_valid_s2 <= r_valid_s1;
    end
  end

  for (genvar k = 0; k < SAMPLES_PER_CLK; k++) begin : g_lane
    dac_gain_lane #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GAIN_WIDTH   (GAIN_WIDTH)
    ) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_sample   (bus.data_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .i_gain     (r_gain),
      .i_valid_s1 (r_valid_s1),
      .o_sample   (w_data_out[k*SAMPLE_WIDTH +: SAMPLE_WIDTH])
    );
  end

  assign bus.data_out       = w_data_out;
  assign bus.data_out_valid = r_valid_s2;
  assign bus.muted          = r_muted;
  assign bus.active         = r_active;
  assign bus.ramp_done      = r_ramp_done;

endmodule : dac_soft_mute

// File: tb/tb_dac_soft_mute.sv
// tb_dac_soft_mute: scoreboard bench for dac_soft_mute (8 x 16-bit lanes).
module tb_dac_soft_mute;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int GW = 16;

  localparam int ST_MUTED = 0;
  localparam int ST_UP    = 1;
  localparam int ST_ACT   = 2;
  localparam int ST_DOWN  = 3;

`ifdef DAC_SOFT_MUTE_OFFSET_BINARY_EN
  localparam logic [15:0] IDLE_LANE = 16'h8000;
`else
  localparam logic [15:0] IDLE_LANE = 16'h0000;
`endif

  typedef struct {
    int             idx;
    logic           valid;
    logic [N*W-1:0] data;
  } sb_entry_t;

  logic clk;
  logic rst_n;

  dac_soft_mute_if #(.SAMPLES_PER_CLK(N), .SAMPLE_WIDTH(W), .GAIN_WIDTH(GW)) bus ();

  dac_soft_mute #(
    .SAMPLES_PER_CLK (N),
    .SAMPLE_WIDTH    (W),
    .GAIN_WIDTH      (GW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        m_state  = ST_MUTED;
  int        m_gain   = 0;
  bit        m_done   = 1'b0;
  sb_entry_t sb[$];

  task automatic check_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] fill(input logic [15:0] v);
    return {N{v}};
  endfunction

  // Expected output word for input din at gain g.
  function automatic logic [N*W-1:0] model_out(input logic [N*W-1:0] din, input int g, input bit v);
    logic [N*W-1:0] r;
    longint         p;
    longint         y;
    logic [15:0]    s;
    for (int k = 0; k < N; k++) begin
      if (!v) begin
        r[16*k +: 16] = IDLE_LANE;
      end else begin
        s = din[16*k +: 16];
        p = longint'(shortint'(s)) * longint'(g);
        y = (p + 64'sd16384) >>> 15;
`ifdef DAC_SOFT_MUTE_OFFSET_BINARY_EN
        r[16*k +: 16] = {~y[15], y[14:0]};
`else
        r[16*k +: 16] = y[15:0];
`endif
      end
    end
    return r;
  endfunction

  task automatic model_step(input bit en, input int step, input bit v);
    int se;
    m_done = 1'b0;
    if (v) begin
      se = (step == 0) ? 1 : step;
      case (m_state)
        ST_MUTED: if (en) m_state = ST_UP;
        ST_UP: begin
          if (!en) m_state = ST_DOWN;
          else if (m_gain + se >= 32768) begin
            m_gain = 32768; m_state = ST_ACT; m_done = 1'b1;
          end else m_gain = m_gain + se;
        end
        ST_ACT: if (!en) m_state = ST_DOWN;
        default: begin
          if (en) m_state = ST_UP;
          else if (m_gain <= se) begin
            m_gain = 0; m_state = ST_MUTED; m_done = 1'b1;
          end else m_gain = m_gain - se;
        end
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dout"},  bus.data_out, fill(IDLE_LANE));
    check_eq({tag, "_vld"},   bus.data_out_valid, 1'b0);
    check_eq({tag, "_muted"}, bus.muted, 1'b1);
    check_eq({tag, "_act"},   bus.active, 1'b0);
    check_eq({tag, "_done"},  bus.ramp_done, 1'b0);
  endtask

  // Assert reset away from a clock edge, hold for two edges, release mid-cycle.
  task automatic do_reset();
    bus.data_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) begin
      @(posedge clk); cyc++;
    end
    #3;
    rst_n = 1'b1;
    m_state = ST_MUTED;
    m_gain  = 0;
    sb.delete();
    sb.push_back('{idx: cyc - 1, valid: 1'b0, data: fill(IDLE_LANE)});
  endtask

  // One clock: drive a word, score it, advance the model, check flags and output.
  task automatic drive_cycle(input bit en, input logic [15:0] step, input bit v, input logic [N*W-1:0] din);
    sb_entry_t e;
    bus.enable        = en;
    bus.ramp_step     = step;
    bus.data_in       = din;
    bus.data_in_valid = v;
    e.idx   = cyc;
    e.valid = v;
    e.data  = model_out(din, m_gain, v);
    sb.push_back(e);
    model_step(en, int'(step), v);
    @(posedge clk); cyc++;
    #1;
    check_eq("muted",     bus.muted,     m_state == ST_MUTED);
    check_eq("active",    bus.active,    m_state == ST_ACT);
    check_eq("ramp_done", bus.ramp_done, m_done);
    while (sb.size() > 0 && sb[0].idx <= cyc - 2) begin
      e = sb.pop_front();
      check_eq("dout_valid", bus.data_out_valid, e.valid);
      check_eq("dout",       bus.data_out,       e.data);
    end
  endtask

  logic [N*W-1:0] round_vec;
  logic [N*W-1:0] rnd_vec;

  initial begin
    rst_n             = 1'b1;
    bus.enable        = 1'b0;
    bus.ramp_step     = '0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    round_vec = {16'h0000, 16'h1234, 16'hC000, 16'h0001,
                 16'h8000, 16'h7FFF, 16'hFFFD, 16'hFFFF};
    #1;

    // Reset and idle: muted, zero output, no ramp_done.
    do_reset();
    repeat (6) drive_cycle(1'b0, 16'h4000, 1'b1, fill(16'h7FFF));

    // Unmute with step 0x4000: outputs 0, 0, 0x2000, 0x4000.
    repeat (6) drive_cycle(1'b1, 16'h4000, 1'b1, fill(16'h4000));

    // Ramp down, gain passes 0x4000: rounding of -1, -3, 0x7FFF and others.
    repeat (6) drive_cycle(1'b0, 16'h4000, 1'b1, round_vec);

    // Mid-ramp reversal with step 0x0100, random lanes.
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < N; k++) rnd_vec[16*k +: 16] = 16'($urandom);
      drive_cycle(i < 10, 16'h0100, 1'b1, rnd_vec);
    end

    // Step zero with stalls: gain moves 1 LSB per valid word only.
    for (int i = 0; i < 24; i++) drive_cycle(1'b1, 16'h0000, (i % 2) == 0, fill(16'h8000));
    repeat (5) drive_cycle(1'b1, 16'h0000, 1'b0, fill(16'h8000));
    repeat (4) drive_cycle(1'b1, 16'h0000, 1'b1, fill(16'h8000));

    // Async reset mid-ramp at gain 0x3000, then restart from MUTED.
    do_reset();
    repeat (4) drive_cycle(1'b1, 16'h1000, 1'b1, fill(16'h7FFF));
    drive_cycle(1'b1, 16'h1000, 1'b0, fill(16'h7FFF));
    #2;
    do_reset();
    repeat (3) drive_cycle(1'b0, 16'h1000, 1'b1, fill(16'h7FFF));
    repeat (12) drive_cycle(1'b1, 16'h1000, 1'b1, fill(16'h8001));

    // Flush the pipeline.
    repeat (3) drive_cycle(1'b1, 16'h1000, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dac_soft_mute
